// File: rtl/imm_ext_pipe.sv
// Immediate-extension decode stage: the extension is computed at the input and the
// result is stored in a two-entry skid buffer (OUT + SKID) with a registered in_ready.
module imm_ext_pipe #(
    parameter int IMM_W  = 16,
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IMM_W-1:0]  in_imm,
    input  logic [2:0]        in_mode,
    input  logic [DATA_W-1:0] in_pc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_err
);

    typedef struct packed {
        logic              err;
        logic [DATA_W-1:0] data;
    } ent_t;

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    localparam int                EXT_W  = DATA_W - IMM_W;
    localparam logic [DATA_W-1:0] PC_INC = DATA_W'(4);

    ent_t              ext;
    ent_t              out_q;
    ent_t              skid_q;
    state_t            state;
    logic [DATA_W-1:0] sext;
    logic [DATA_W-1:0] sext_sh2;
    logic              in_hs;
    logic              out_hs;

    assign sext     = {{EXT_W{in_imm[IMM_W-1]}}, in_imm};
    assign sext_sh2 = {sext[DATA_W-3:0], 2'b00};

    always_comb begin
        ext = '0;
        case (in_mode)
            3'b000:  ext.data = {{EXT_W{1'b0}}, in_imm};
            3'b001:  ext.data = sext;
            3'b010:  ext.data = {in_imm, {EXT_W{1'b0}}};
            3'b011:  ext.data = in_pc + PC_INC + sext_sh2;
            3'b100:  ext.data = sext_sh2;
            default: ext.err  = 1'b1;
        endcase
    end

    assign in_hs  = in_valid & in_ready;
    assign out_hs = out_valid & out_ready;

    // in_ready and out_valid are flops tracking the state, so no ready path is combinational.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= EMPTY;
            out_q     <= '0;
            skid_q    <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else if (flush) begin
            state     <= EMPTY;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                EMPTY: if (in_hs) begin
                    out_q     <= ext;
                    out_valid <= 1'b1;
                    state     <= ONE;
                end
                ONE: begin
                    if (in_hs && out_hs) begin
                        out_q <= ext;
                    end else if (in_hs) begin
                        skid_q   <= ext;
                        in_ready <= 1'b0;
                        state    <= FULL;
                    end else if (out_hs) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                FULL: if (out_hs) begin
                    out_q    <= skid_q;
                    in_ready <= 1'b1;
                    state    <= ONE;
                end
                default: begin
                    state     <= EMPTY;
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

    assign out_data = out_q.data;
    assign out_err  = out_q.err;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Bench for imm_ext_pipe: directed vector table, backpressure/flush/reset sequences,
// and a random soak against an arithmetic reference model with a queue.
module tb_imm_ext_pipe;

    localparam int IW = 16;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [IW-1:0] in_imm = '0;
    logic [2:0]    in_mode = '0;
    logic [DW-1:0] in_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [DW-1:0] out_data;
    logic          out_err;

    int checks = 0;
    int errors = 0;

    imm_ext_pipe #(.IMM_W(IW), .DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_imm(in_imm), .in_mode(in_mode), .in_pc(in_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_err(out_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [IW-1:0] imm;
        logic [2:0]    mode;
        logic [DW-1:0] pc;
        logic [DW-1:0] exp_data;
        logic          exp_err;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: {err, data} from the mode rules using plain integer arithmetic.
    function automatic logic [DW:0] ref_ext(input logic [IW-1:0] imm, input logic [2:0] mode,
                                            input logic [DW-1:0] pc);
        longint si = longint'($signed(imm));
        longint u  = longint'(imm);
        longint d  = 0;
        logic   e  = 1'b0;
        case (mode)
            3'd0: d = u;
            3'd1: d = si;
            3'd2: d = u * (64'd1 << (DW - IW));
            3'd3: d = longint'(pc) + 4 + si * 4;
            3'd4: d = si * 4;
            default: begin d = 0; e = 1'b1; end
        endcase
        return {e, d[DW-1:0]};
    endfunction

    task automatic drive(input logic v, input logic [IW-1:0] imm, input logic [2:0] mode,
                         input logic [DW-1:0] pc);
        in_valid = v; in_imm = imm; in_mode = mode; in_pc = pc;
    endtask

    vec_t          vt[9];
    logic [DW:0]   exp_q[$];
    logic [DW:0]   bp_exp[5];
    logic [DW:0]   r;
    logic [DW-1:0] held;
    int            k, j;
    logic          hs, ihs, ohs, seen;

    initial begin
        vt[0] = '{16'h8001, 3'b000, 32'h0,        32'h00008001, 1'b0};
        vt[1] = '{16'h8001, 3'b001, 32'h0,        32'hFFFF8001, 1'b0};
        vt[2] = '{16'h8001, 3'b010, 32'h0,        32'h80010000, 1'b0};
        vt[3] = '{16'h8001, 3'b100, 32'h0,        32'hFFFE0004, 1'b0};
        vt[4] = '{16'h8001, 3'b110, 32'h0,        32'h00000000, 1'b1};
        vt[5] = '{16'hFFFF, 3'b011, 32'h00003000, 32'h00003000, 1'b0};
        vt[6] = '{16'h0001, 3'b011, 32'hFFFFFFFC, 32'h00000004, 1'b0};
        vt[7] = '{16'h7FFF, 3'b101, 32'h0,        32'h00000000, 1'b1};
        vt[8] = '{16'h1234, 3'b010, 32'h0,        32'h12340000, 1'b0};

        // Reset state
        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_err", out_err, 0);
        chk("rst_in_ready", in_ready, 1);
        @(negedge clk); rst_n = 1'b1;

        // Mode sweep, back-to-back, latency one cycle
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, vt[i].imm, vt[i].mode, vt[i].pc);
            @(negedge clk);
            chk($sformatf("vec%0d_valid", i), out_valid, 1);
            chk($sformatf("vec%0d_data", i), out_data, vt[i].exp_data);
            chk($sformatf("vec%0d_err", i), out_err, vt[i].exp_err);
        end
        drive(1'b0, '0, '0, '0);
        @(negedge clk);
        chk("sweep_drained", out_valid, 0);

        // Backpressure: 5 entries with out_ready low
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++) bp_exp[i] = ref_ext(IW'(16'h100 + i), 3'b001, '0);
        k = 0;
        for (int c = 0; c < 5; c++) begin
            drive(k < 5, IW'(16'h100 + k), 3'b001, '0);
            hs = in_valid && in_ready;
            @(posedge clk);
            if (hs) k++;
            @(negedge clk);
            if (c >= 1) chk("bp_stall_data", out_data, bp_exp[0][DW-1:0]);
        end
        chk("bp_accepted", k, 2);
        chk("bp_in_ready_low", in_ready, 0);
        chk("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        j = 0;
        for (int c = 0; c < 20 && j < 5; c++) begin
            drive(k < 5, IW'(16'h100 + k), 3'b001, '0);
            hs = in_valid && in_ready;
            if (out_valid) begin
                chk($sformatf("bp_out%0d", j), {out_err, out_data}, bp_exp[j]);
                j++;
            end else if (j > 0) begin
                chk("bp_no_gap", out_valid, 1);
            end
            @(posedge clk);
            if (hs) k++;
            @(negedge clk);
        end
        chk("bp_all_delivered", j, 5);
        drive(1'b0, '0, '0, '0);
        @(negedge clk);

        // Flush in FULL with an input presented
        out_ready = 1'b0;
        drive(1'b1, 16'h00AA, 3'b000, '0); @(negedge clk);
        drive(1'b1, 16'h00BB, 3'b000, '0); @(negedge clk);
        chk("fl_full", in_ready, 0);
        drive(1'b1, 16'h00CC, 3'b000, '0);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        chk("fl_valid", out_valid, 0);
        chk("fl_in_ready", in_ready, 1);
        // Flush in ONE with an accepted-looking handshake that must be dropped
        drive(1'b1, 16'h00DD, 3'b000, '0); @(negedge clk);
        drive(1'b1, 16'h00EE, 3'b000, '0); flush = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (out_valid) seen = 1'b1;
            @(negedge clk);
        end
        chk("fl_no_ghost", seen, 0);

        // Async reset mid-stream, between edges
        drive(1'b1, 16'h0055, 3'b000, '0); @(negedge clk);
        drive(1'b1, 16'h0066, 3'b000, '0);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_valid", out_valid, 0);
        chk("ar_data", out_data, 0);
        chk("ar_in_ready", in_ready, 1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 16'h0077, 3'b001, '0);
        @(negedge clk);
        drive(1'b0, '0, '0, '0);
        chk("ar_first_valid", out_valid, 1);
        chk("ar_first_data", out_data, 32'h00000077);
        @(negedge clk);

        // Random soak against queue model, starting from a flushed stage
        flush = 1'b1; @(negedge clk); flush = 1'b0;
        exp_q.delete();
        for (int c = 0; c < 3000; c++) begin
            chk("soak_valid", out_valid, exp_q.size() > 0);
            chk("soak_in_ready", in_ready, exp_q.size() < 2);
            if (exp_q.size() > 0) chk("soak_entry", {out_err, out_data}, exp_q[0]);
            drive($urandom_range(0, 3) != 0, IW'($urandom), 3'($urandom_range(0, 7)), DW'($urandom));
            out_ready = $urandom_range(0, 2) != 0;
            flush     = $urandom_range(0, 19) == 0;
            ihs = in_valid && (exp_q.size() < 2);
            ohs = out_ready && (exp_q.size() > 0);
            r   = ref_ext(in_imm, in_mode, in_pc);
            if (flush) exp_q.delete();
            else begin
                if (ohs) void'(exp_q.pop_front());
                if (ihs) exp_q.push_back(r);
            end
            @(negedge clk);
        end
        flush = 1'b0;
        drive(1'b0, '0, '0, '0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
